// File: rtl/serial_pkg.sv
// Shared types and constants for the byte-serial link.
package serial_pkg;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    localparam int SER_W        = 8;
    localparam int BYTES_SINGLE = 2;
    localparam int BYTES_DOUBLE = 4;
    // FIFO entry: {word_double, word_in}
    localparam int FRAME_W      = 33;

endpackage

// File: rtl/word_fifo.sv
// Synchronous frame FIFO with combinational head read; DEPTH must be a power of 2.
module word_fifo
    import serial_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [FRAME_W-1:0] din,
    output logic [FRAME_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally at AW bits because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Byte-serial transmitter: buffers 16/32-bit frames and sends them MSB byte first,
// with tx_ready backpressure and a sticky overflow flag for pushes while full.
module word_serializer
    import serial_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             word_valid,
    input  logic [31:0]      word_in,
    input  logic             word_double,
    output logic             word_ready,
    input  logic             tx_ready,
    output logic             data_ready,
    output logic [SER_W-1:0] serial_out,
    output logic             busy,
    output logic             overflow
);

    tx_state_t          state;
    logic [31:0]        shift;
    logic [2:0]         bytes_left;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [FRAME_W-1:0] fifo_dout;
    logic               last_xfer;
    logic [31:0]        load_shift;
    logic [2:0]         load_bytes;

    word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({word_double, word_in}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign word_ready = ~fifo_full;
    assign fifo_push  = word_valid & ~fifo_full;
    assign last_xfer  = (state == TX_SEND) & tx_ready & (bytes_left == 3'd1);
    // Pop when idle or on the last byte, so consecutive frames leave no bubble.
    assign fifo_pop   = ~fifo_empty & ((state == TX_IDLE) | last_xfer);

    // 16-bit frames are left-aligned so the current byte is always shift[31:24].
    assign load_shift = fifo_dout[32] ? fifo_dout[31:0] : {fifo_dout[15:0], 16'h0};
    assign load_bytes = fifo_dout[32] ? 3'(BYTES_DOUBLE) : 3'(BYTES_SINGLE);

    assign serial_out = shift[31:24];
    assign busy       = (state == TX_SEND) | ~fifo_empty;

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TX_IDLE;
            shift      <= '0;
            bytes_left <= '0;
            data_ready <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (word_valid && fifo_full) overflow <= 1'b1;

            if (state == TX_IDLE) begin
                if (!fifo_empty) begin
                    shift      <= load_shift;
                    bytes_left <= load_bytes;
                    data_ready <= 1'b1;
                    state      <= TX_SEND;
                end
            end else if (tx_ready) begin
                if (last_xfer && !fifo_empty) begin
                    shift      <= load_shift;
                    bytes_left <= load_bytes;
                end else begin
                    shift      <= {shift[23:0], 8'h0};
                    bytes_left <= bytes_left - 3'd1;
                    if (last_xfer) begin
                        data_ready <= 1'b0;
                        state      <= TX_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: a byte scoreboard fed by the stimulus and drained by a monitor.
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        word_valid;
    logic [31:0] word_in;
    logic        word_double;
    logic        word_ready;
    logic        tx_ready;
    logic        data_ready;
    logic [7:0]  serial_out;
    logic        busy;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb [$];

    word_serializer #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .word_valid  (word_valid),
        .word_in     (word_in),
        .word_double (word_double),
        .word_ready  (word_ready),
        .tx_ready    (tx_ready),
        .data_ready  (data_ready),
        .serial_out  (serial_out),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One stimulus cycle: inputs change 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [31:0] w, input logic d);
        @(posedge clk);
        #1;
        word_valid  = v;
        word_in     = w;
        word_double = d;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic expect_frame(input logic [31:0] w, input logic d);
        if (d) begin
            sb.push_back(w[31:24]);
            sb.push_back(w[23:16]);
        end
        sb.push_back(w[15:8]);
        sb.push_back(w[7:0]);
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            idle();
            if (!busy && !data_ready) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_timeout", 64'(done), 64'd1);
    endtask

    // A transfer happens on the coming edge whenever data_ready & tx_ready at the falling edge.
    always @(negedge clk) begin
        if (rst_n && data_ready && tx_ready) begin
            if (sb.size() == 0) check("sb_underflow", 64'(sb.size()), 64'd1);
            else                check("byte", 64'(serial_out), 64'(sb.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp3 [6];
        logic [31:0] f5_word [6];
        logic        f5_dbl  [6];

        exp3    = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0F, 8'h0F};
        f5_word = '{32'h0000A001, 32'hB0B1B2B3, 32'h0000A003, 32'h0000A004, 32'hC0C1C2C3, 32'h0000A006};
        f5_dbl  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; word_valid = 1'b0; word_in = '0; word_double = 1'b0; tx_ready = 1'b1;
        #2;
        check("rst_data_ready", 64'(data_ready), 64'd0);
        check("rst_serial_out", 64'(serial_out), 64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_overflow",   64'(overflow),   64'd0);
        check("rst_word_ready", 64'(word_ready), 64'd1);
        #20 rst_n = 1'b1;

        // Single 16-bit frame: latency and end of frame.
        drive(1'b1, 32'h00001234, 1'b0); expect_frame(32'h00001234, 1'b0);
        idle();
        check("lat_n1_dr", 64'(data_ready), 64'd0);
        idle();
        check("lat_n2_dr", 64'(data_ready), 64'd1);
        check("lat_n2_byte", 64'(serial_out), 64'h12);
        idle();
        check("lat_n3_byte", 64'(serial_out), 64'h34);
        idle();
        check("lat_n4_dr", 64'(data_ready), 64'd0);
        check("lat_n4_busy", 64'(busy), 64'd0);

        // Back-to-back mixed frames with no gap.
        drive(1'b1, 32'hDEADBEEF, 1'b1); expect_frame(32'hDEADBEEF, 1'b1);
        drive(1'b1, 32'h00000F0F, 1'b0); expect_frame(32'h00000F0F, 1'b0);
        idle();
        for (int i = 0; i < 6; i++) begin
            check("b2b_dr", 64'(data_ready), 64'd1);
            check("b2b_byte", 64'(serial_out), 64'(exp3[i]));
            idle();
        end
        check("b2b_end_dr", 64'(data_ready), 64'd0);

        // Backpressure: byte held stable for 5 cycles.
        tx_ready = 1'b0;
        drive(1'b1, 32'h11223344, 1'b1); expect_frame(32'h11223344, 1'b1);
        idle();
        idle();
        for (int i = 0; i < 5; i++) begin
            check("bp_dr", 64'(data_ready), 64'd1);
            check("bp_stable", 64'(serial_out), 64'h11);
            idle();
        end
        tx_ready = 1'b1;
        wait_idle(20);

        // Fill and overflow: 1 frame in the shift register, 4 buffered, 6th dropped.
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, f5_word[i], f5_dbl[i]);
            check("full_word_ready", 64'(word_ready), (i < 5) ? 64'd1 : 64'd0);
            if (i < 5) expect_frame(f5_word[i], f5_dbl[i]);
        end
        idle();
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_full", 64'(word_ready), 64'd0);
        idle(); idle(); idle();
        check("ovf_sticky", 64'(overflow), 64'd1);
        tx_ready = 1'b1;
        wait_idle(40);
        check("ovf_after_drain", 64'(overflow), 64'd1);
        check("drain_word_ready", 64'(word_ready), 64'd1);

        // Push lands on the same cycle as the last-byte pop.
        drive(1'b1, 32'h0000C0DE, 1'b0); expect_frame(32'h0000C0DE, 1'b0);
        drive(1'b1, 32'h00001357, 1'b0); expect_frame(32'h00001357, 1'b0);
        idle();
        check("pp_dr_start", 64'(data_ready), 64'd1);
        drive(1'b1, 32'h2468ACE0, 1'b1); expect_frame(32'h2468ACE0, 1'b1);
        check("pp_word_ready", 64'(word_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            idle();
            check("pp_dr", 64'(data_ready), 64'd1);
        end
        idle();
        check("pp_end_dr", 64'(data_ready), 64'd0);

        // Reset mid-frame: outputs drop at once, buffered data discarded.
        drive(1'b1, 32'hDEADBEEF, 1'b1); expect_frame(32'hDEADBEEF, 1'b1);
        drive(1'b1, 32'h00005555, 1'b0);
        idle();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_data_ready", 64'(data_ready), 64'd0);
        check("mid_rst_serial_out", 64'(serial_out), 64'd0);
        check("mid_rst_busy",       64'(busy),       64'd0);
        check("mid_rst_overflow",   64'(overflow),   64'd0);
        check("mid_rst_word_ready", 64'(word_ready), 64'd1);
        sb.delete();
        word_valid = 1'b1; word_in = 32'h00007777; word_double = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        word_valid = 1'b0;
        rst_n = 1'b1;
        idle();
        idle();
        check("rst_push_ignored_dr", 64'(data_ready), 64'd0);
        check("rst_push_ignored_busy", 64'(busy), 64'd0);
        drive(1'b1, 32'h0000A5C3, 1'b0); expect_frame(32'h0000A5C3, 1'b0);
        wait_idle(20);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
